// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master = pipeline datapath side, slave = hazard_ctrl side.
interface hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_jr;
    logic       idex_memRead;
    logic       idex_regWrite;
    logic [4:0] idex_rd;
    logic       exmem_regWrite;
    logic [4:0] exmem_rd;
    logic       exmem_mem_req;
    logic       mem_ready;
    logic       exmem_branch_taken;

    logic       pc_write;
    logic       ifid_write;
    logic       idex_bubble;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       pipe_freeze;
    logic       mem_err;

    modport master (
        output id_rs, id_rt, id_jr, idex_memRead, idex_regWrite, idex_rd,
               exmem_regWrite, exmem_rd, exmem_mem_req, mem_ready, exmem_branch_taken,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
               exmem_flush, pipe_freeze, mem_err
    );

    modport slave (
        input  id_rs, id_rt, id_jr, idex_memRead, idex_regWrite, idex_rd,
               exmem_regWrite, exmem_rd, exmem_mem_req, mem_ready, exmem_branch_taken,
        output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
               exmem_flush, pipe_freeze, mem_err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/jr stalls, branch flushes, data-memory freeze with timeout.
// Optional HAZARD_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]   stall_cnt,
    output logic [15:0]   flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          err_q, err_nxt;

    logic pc_write, ifid_write, idex_bubble;
    logic ifid_flush, idex_flush, exmem_flush, pipe_freeze;
    logic load_use, jr_haz, mem_stall;

    always_comb begin
        load_use = hz.idex_memRead && (hz.idex_rd != 5'd0) &&
                   ((hz.idex_rd == hz.id_rs) || (hz.idex_rd == hz.id_rt));
        jr_haz   = hz.id_jr && (hz.id_rs != 5'd0) &&
                   ((hz.idex_regWrite && (hz.idex_rd == hz.id_rs)) ||
                    (hz.exmem_regWrite && (hz.exmem_rd == hz.id_rs)));
        mem_stall = hz.exmem_mem_req && !hz.mem_ready;
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_freeze = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;
        err_nxt     = err_q;

        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_stall) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        pipe_freeze = 1'b1;
                        state_nxt   = MEM_WAIT;
                        cnt_nxt     = CNT_ONE;
                    end else if (hz.exmem_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (load_use || jr_haz) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Freeze holds through the completing cycle; release shows up next cycle.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_freeze = 1'b1;
                    if (hz.mem_ready) begin
                        state_nxt = RUN;
                    end else if (cnt == TMO) begin
                        state_nxt = RUN;
                        err_nxt   = 1'b1;
                    end else if (cnt != '1) begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.idex_bubble = idex_bubble;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_flush = exmem_flush;
    assign hz.pipe_freeze = pipe_freeze;
    assign hz.mem_err     = err_q;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
            if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule
